stumps_signature_checker: RTL and testbench
===========================================

Name: stumps_signature_checker

Overview:
- Test-access side of the STUMPS BIST: launches a BIST session, waits for the controller's done, serially unloads the final MISR signature, and compares it against a golden value.
- Sits between the chip test port (start/result flags) and the STUMPS controller/MISR pair.
- Drives the controller's reset input; consumes its done output and the MISR serial scan-out.

Parameters:
SigWidth, 16, MISR signature width in bits
GoldenSig, 16'hA5C3, expected fault-free signature (SigWidth bits)
TimeoutCycles, 4096, max cycles in WaitDone before declaring timeout (≥2)
CntW, 5, mismatch counter width, = clog2(SigWidth+1)

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  request a BIST session; sampled only in Idle
bistDone  input  1  done from STUMPS controller, level
misrSerialOut  input  1  MISR scan-out bit, MSB first
bistRst  output  1  active-high reset pulse to controller rstIn
misrShiftEn  output  1  MISR unload shift enable
busy  output  1  session in progress (any state but Idle)
pass  output  1  last session signature matched GoldenSig
fail  output  1  last session mismatched or timed out
timeout  output  1  last session timed out waiting for bistDone
signature  output  SigWidth  captured MISR signature
mismatchCount  output  CntW  popcount(signature ^ GoldenSig)

Behaviour:
- Clock and reset: one clock domain; rstN asynchronous, active-low. While rstN=0: state=Idle; every output 0, including signature and mismatchCount; internal counters 0.
- FSM states: Idle, Launch, WaitDone, Unload, Compare, Report.
- Idle:
  - busy=0; results hold their last values.
  - start=1 -> Launch.
- Launch (exactly 1 cycle):
  - bistRst=1.
  - Clear pass, fail, timeout, signature, mismatchCount, timeout counter and bit counter.
  - -> WaitDone.
  - bistDone is ignored here: a stale done from the previous session must not be accepted.
- WaitDone:
  - Timeout counter increments every cycle.
  - bistDone=1 -> Unload.
  - Else, counter == TimeoutCycles-1 -> Report with timeout=1, fail=1.
  - If bistDone and the timeout condition occur in the same cycle, done wins (-> Unload, no timeout).
- Unload (exactly SigWidth cycles):
  - misrShiftEn=1 for all SigWidth cycles.
  - Each rising edge: signature <= {signature[SigWidth-2:0], misrSerialOut}; bit counter +1.
  - The first sampled bit is the MISR MSB.
  - After the last bit (count == SigWidth-1) -> Compare.
  - misrShiftEn deasserts in the cycle after the final sample.
- Compare (1 cycle):
  - mismatchCount <= popcount(signature ^ GoldenSig).
  - pass <= (signature == GoldenSig); fail <= !pass condition.
  - -> Report.
- Report (1 cycle): -> Idle. pass, fail, timeout, signature and mismatchCount stay sticky until the next Launch.
- Invariants: pass and fail are never both 1. busy=1 in Launch through Report.
- start while busy: ignored, not queued.
- start held high: a new session launches on the first Idle cycle after Report, one session per Idle visit.
- Latency, start to pass/fail, when done arrives k cycles after entering WaitDone: 1 (Launch) + k+1 (WaitDone) + SigWidth (Unload) + 1 (Compare). Flags are visible the cycle after Compare.
- Reset mid-session: immediate return to Idle with all outputs 0. bistRst and misrShiftEn drop asynchronously.

Test Plan:
- Reset: rstN=0 for 3 cycles with start=1 -> all outputs 0, busy=0; rstN release with start=1 -> bistRst single-cycle pulse on the next edge.
- Golden pass: start; bistDone after 50 cycles; shift 16'hA5C3 MSB first -> exactly 16 cycles misrShiftEn=1, signature=16'hA5C3, pass=1, fail=0, mismatchCount=0, busy falls after Report.
- Mismatch: shift 16'hA5C0 -> pass=0, fail=1, mismatchCount=2, signature=16'hA5C0; flags remain stable for 20 Idle cycles.
- Timeout: TimeoutCycles=8, bistDone never asserted -> after 8 WaitDone cycles timeout=1, fail=1, misrShiftEn never asserted; done asserted on cycle 8 exactly instead -> Unload, timeout=0.
- Stale done / busy start: bistDone held 1 through Launch -> not accepted in Launch (enters WaitDone, accepted next cycle); start pulses during Unload -> no extra bistRst pulse, one session only.
- Reset mid-Unload: assert rstN=0 after 7 shifted bits -> misrShiftEn=0 immediately, signature=0, state Idle; next start runs a clean full session to pass.

Source files
------------

// File: rtl/stumps_signature_checker_if.sv
// Signal bundle between the chip test port / STUMPS controller and the checker.
// The checker uses the slave view; whatever drives start, done and scan-out uses master.
interface stumps_signature_checker_if #(
  parameter int SigWidth = 16,
  parameter int CntW     = 5
);
  logic                start;
  logic                bistDone;
  logic                misrSerialOut;
  logic                bistRst;
  logic                misrShiftEn;
  logic                busy;
  logic                pass;
  logic                fail;
  logic                timeout;
  logic [SigWidth-1:0] signature;
  logic [CntW-1:0]     mismatchCount;

  modport master (
    output start, bistDone, misrSerialOut,
    input  bistRst, misrShiftEn, busy, pass, fail, timeout, signature, mismatchCount
  );

  modport slave (
    input  start, bistDone, misrSerialOut,
    output bistRst, misrShiftEn, busy, pass, fail, timeout, signature, mismatchCount
  );
endinterface

// File: rtl/stumps_signature_checker.sv
// Launches a STUMPS BIST session, waits for done, serially unloads the MISR
// signature (MSB first) and compares it against the golden value.
//
// state    | meaning
// ---------+------------------------------------------------------------
// Idle     | no session; result flags hold, start launches a session
// Launch   | one-cycle bistRst pulse, clears results and counters
// WaitDone | waits for bistDone, counts cycles toward timeout
// Unload   | SigWidth cycles of misrShiftEn, shifts scan-out into signature
// Compare  | computes pass/fail and mismatch popcount
// Report   | one cycle with final results, then back to Idle
module stumps_signature_checker #(
  parameter int                  SigWidth      = 16,
  parameter logic [SigWidth-1:0] GoldenSig     = 16'hA5C3,
  parameter int                  TimeoutCycles = 4096,
  parameter int                  CntW          = 5
) (
  input logic                       clk,
  input logic                       rstN,
  stumps_signature_checker_if.slave bus
);

  localparam int TW = $clog2(TimeoutCycles);
  localparam int BW = $clog2(SigWidth);

  typedef enum logic [2:0] {
    Idle,
    Launch,
    WaitDone,
    Unload,
    Compare,
    Report
  } stateT;

  stateT               state;
  logic [TW-1:0]       toCnt;
  logic [BW-1:0]       bitCnt;
  logic                bistRstQ;
  logic                shiftEnQ;
  logic                busyQ;
  logic                passQ;
  logic                failQ;
  logic                timeoutQ;
  logic [SigWidth-1:0] sigQ;
  logic [CntW-1:0]     mismatchQ;

  function automatic logic [CntW-1:0] popCount(input logic [SigWidth-1:0] v);
    logic [CntW-1:0] n;
    n = '0;
    for (int i = 0; i < SigWidth; i++) begin
      n = n + CntW'(v[i]);
    end
    return n;
  endfunction

  // Session sequencer; every output is a register so nothing glitches toward the controller.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= Idle;
      toCnt     <= '0;
      bitCnt    <= '0;
      bistRstQ  <= 1'b0;
      shiftEnQ  <= 1'b0;
      busyQ     <= 1'b0;
      passQ     <= 1'b0;
      failQ     <= 1'b0;
      timeoutQ  <= 1'b0;
      sigQ      <= '0;
      mismatchQ <= '0;
    end else begin
      bistRstQ <= 1'b0;
      case (state)
        Idle: begin
          if (bus.start) begin
            state    <= Launch;
            bistRstQ <= 1'b1;
            busyQ    <= 1'b1;
          end
        end
        // bistDone is deliberately not looked at here: it may still be the previous session's done.
        Launch: begin
          passQ     <= 1'b0;
          failQ     <= 1'b0;
          timeoutQ  <= 1'b0;
          sigQ      <= '0;
          mismatchQ <= '0;
          toCnt     <= '0;
          bitCnt    <= '0;
          state     <= WaitDone;
        end
        // Done has priority over a timeout landing in the same cycle.
        WaitDone: begin
          toCnt <= toCnt + 1'b1;
          if (bus.bistDone) begin
            state    <= Unload;
            shiftEnQ <= 1'b1;
          end else if (toCnt == TW'(TimeoutCycles - 1)) begin
            state    <= Report;
            timeoutQ <= 1'b1;
            failQ    <= 1'b1;
          end
        end
        Unload: begin
          sigQ   <= {sigQ[SigWidth-2:0], bus.misrSerialOut};
          bitCnt <= bitCnt + 1'b1;
          if (bitCnt == BW'(SigWidth - 1)) begin
            state    <= Compare;
            shiftEnQ <= 1'b0;
          end
        end
        Compare: begin
          mismatchQ <= popCount(sigQ ^ GoldenSig);
          passQ     <= (sigQ == GoldenSig);
          failQ     <= (sigQ != GoldenSig);
          state     <= Report;
        end
        Report: begin
          state <= Idle;
          busyQ <= 1'b0;
        end
        default: begin
          state    <= Idle;
          busyQ    <= 1'b0;
          shiftEnQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bistRst       = bistRstQ;
  assign bus.misrShiftEn   = shiftEnQ;
  assign bus.busy          = busyQ;
  assign bus.pass          = passQ;
  assign bus.fail          = failQ;
  assign bus.timeout       = timeoutQ;
  assign bus.signature     = sigQ;
  assign bus.mismatchCount = mismatchQ;

endmodule

// File: tb/tb_stumps_signature_checker.sv
// Scoreboard bench: two checkers (long and short timeout) share one stimulus stream.
module tb_stumps_signature_checker;
  localparam logic [15:0] Gold = 16'hA5C3;
  localparam int NoDone = 5000;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b0;
  logic bistDone = 1'b0;
  logic misrSerialOut = 1'b0;
  logic [15:0] misrReg = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stumps_signature_checker_if #(.SigWidth(16), .CntW(5)) ifA ();
  stumps_signature_checker_if #(.SigWidth(16), .CntW(5)) ifB ();

  assign ifA.start = start;
  assign ifA.bistDone = bistDone;
  assign ifA.misrSerialOut = misrSerialOut;
  assign ifB.start = start;
  assign ifB.bistDone = bistDone;
  assign ifB.misrSerialOut = misrSerialOut;

  stumps_signature_checker #(.SigWidth(16), .GoldenSig(16'hA5C3), .TimeoutCycles(4096), .CntW(5))
    dutA (.clk(clk), .rstN(rstN), .bus(ifA.slave));
  stumps_signature_checker #(.SigWidth(16), .GoldenSig(16'hA5C3), .TimeoutCycles(8), .CntW(5))
    dutB (.clk(clk), .rstN(rstN), .bus(ifB.slave));

  logic busyO [2];
  logic rstO [2];
  logic shO [2];
  logic passO [2];
  logic failO [2];
  logic tmoO [2];
  logic [15:0] sigO [2];
  logic [4:0] mcO [2];
  assign busyO[0] = ifA.busy;          assign busyO[1] = ifB.busy;
  assign rstO[0]  = ifA.bistRst;       assign rstO[1]  = ifB.bistRst;
  assign shO[0]   = ifA.misrShiftEn;   assign shO[1]   = ifB.misrShiftEn;
  assign passO[0] = ifA.pass;          assign passO[1] = ifB.pass;
  assign failO[0] = ifA.fail;          assign failO[1] = ifB.fail;
  assign tmoO[0]  = ifA.timeout;       assign tmoO[1]  = ifB.timeout;
  assign sigO[0]  = ifA.signature;     assign sigO[1]  = ifB.signature;
  assign mcO[0]   = ifA.mismatchCount; assign mcO[1]   = ifB.mismatchCount;

  typedef struct {
    logic [15:0] sig;
    bit pass;
    bit fail;
    bit tmo;
    int mcnt;
    int busyCyc;
    int shifts;
    int rsts;
  } expT;

  expT q0[$];
  expT q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: done arriving k cycles into WaitDone beats a T-cycle timeout iff k < T.
  function automatic expT model(input int tmoCycles, input int k, input logic [15:0] v);
    expT e;
    if (k >= tmoCycles) begin
      e.sig = '0; e.pass = 0; e.fail = 1; e.tmo = 1; e.mcnt = 0;
      e.busyCyc = tmoCycles + 2; e.shifts = 0; e.rsts = 1;
    end else begin
      e.sig = v; e.pass = (v == Gold); e.fail = (v != Gold); e.tmo = 0;
      e.mcnt = $countones(v ^ Gold);
      e.busyCyc = 1 + (k + 1) + 16 + 1 + 1; e.shifts = 16; e.rsts = 1;
    end
    return e;
  endfunction

  task automatic pushExp(input int k, input logic [15:0] v);
    q0.push_back(model(4096, k, v));
    q1.push_back(model(8, k, v));
    misrReg = v;
  endtask

  // MISR stand-in: presents the next bit, MSB first, whenever shift enable is seen.
  always @(negedge clk) begin
    if (rstN && ifA.misrShiftEn) begin
      misrSerialOut = misrReg[15];
      misrReg = misrReg << 1;
    end
  end

  bit prevBusy [2];
  int busyCnt [2];
  int rstCnt [2];
  int shCnt [2];

  task automatic report(input int i);
    expT e;
    string t;
    t = (i == 0) ? "A" : "B";
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      check({t, ".unexpectedSession"}, 1, 0);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      check({t, ".signature"}, 32'(sigO[i]), 32'(e.sig));
      check({t, ".pass"}, 32'(passO[i]), 32'(e.pass));
      check({t, ".fail"}, 32'(failO[i]), 32'(e.fail));
      check({t, ".timeout"}, 32'(tmoO[i]), 32'(e.tmo));
      check({t, ".mismatchCount"}, 32'(mcO[i]), 32'(e.mcnt));
      check({t, ".busyCycles"}, 32'(busyCnt[i]), 32'(e.busyCyc));
      check({t, ".shiftCycles"}, 32'(shCnt[i]), 32'(e.shifts));
      check({t, ".bistRstCycles"}, 32'(rstCnt[i]), 32'(e.rsts));
      check({t, ".passAndFail"}, 32'(passO[i] & failO[i]), 0);
    end
    busyCnt[i] = 0;
    rstCnt[i] = 0;
    shCnt[i] = 0;
  endtask

  // Monitor: a falling busy means a session result is on the outputs.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        prevBusy[i] = 0; busyCnt[i] = 0; rstCnt[i] = 0; shCnt[i] = 0;
      end else begin
        if (busyO[i]) busyCnt[i]++;
        if (rstO[i]) rstCnt[i]++;
        if (shO[i]) shCnt[i]++;
        if (prevBusy[i] && !busyO[i]) report(i);
        prevBusy[i] = busyO[i];
      end
    end
  end

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while ((ifA.busy || ifB.busy) && n < maxCyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("idleWait", 32'(ifA.busy | ifB.busy), 0);
  endtask

  // Called one cycle into WaitDone (just after the Launch->WaitDone edge).
  task automatic finishSession(input int k, input bit startInUnload);
    int n;
    if (k < NoDone) begin
      repeat (k) @(posedge clk);
      #1 bistDone = 1;
      n = 0;
      while (!ifA.misrShiftEn && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("shiftEnRise", 32'(ifA.misrShiftEn), 1);
      bistDone = 0;
      if (startInUnload) begin
        repeat (3) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
      end
    end
    waitIdle(5000);
  endtask

  task automatic session(input int k, input logic [15:0] v, input bit stale, input bit startInUnload);
    waitIdle(100);
    pushExp(k, v);
    if (stale) bistDone = 1;
    start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    finishSession(k, startInUnload);
  endtask

  initial begin
    logic [15:0] v;
    int k;

    // Reset with start held high.
    start = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(ifA.busy), 0);
    check("rst.bistRst", 32'(ifA.bistRst), 0);
    check("rst.shiftEn", 32'(ifA.misrShiftEn), 0);
    check("rst.flags", 32'({ifA.pass, ifA.fail, ifA.timeout}), 0);
    check("rst.signature", 32'(ifA.signature), 0);
    check("rst.mismatchCount", 32'(ifA.mismatchCount), 0);
    check("rstB.busy", 32'(ifB.busy | ifB.bistRst), 0);
    pushExp(10, Gold);
    @(posedge clk); #3 rstN = 1;
    @(posedge clk); #1;
    check("release.bistRst", 32'(ifA.bistRst), 1);
    start = 0;
    @(posedge clk); #1;
    check("release.bistRstOneCycle", 32'(ifA.bistRst), 0);
    finishSession(10, 0);

    // Golden pass with late done, then mismatch with sticky flags.
    session(50, Gold, 0, 0);
    session(5, 16'hA5C0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("hold.signature", 32'(ifA.signature), 32'(16'hA5C0));
    check("hold.fail", 32'(ifA.fail), 1);
    check("hold.pass", 32'(ifA.pass), 0);
    check("hold.mismatchCount", 32'(ifA.mismatchCount), 2);

    // Done exactly on the last allowed cycle for B, then one cycle too late.
    session(7, 16'h1234, 0, 0);
    session(8, Gold, 0, 0);

    // Stale done through Launch; start pulsed while unloading.
    session(0, Gold, 1, 0);
    session(3, 16'h5A3C, 0, 1);

    // Randomized sessions straddling the short timeout.
    for (int r = 0; r < 8; r++) begin
      v = (r % 3 == 0) ? Gold : 16'($urandom);
      k = $urandom_range(0, 12);
      session(k, v, 0, 0);
    end

    // Done never arrives: both checkers time out.
    session(NoDone, 16'h0, 0, 0);

    // Reset after 7 shifted bits.
    waitIdle(100);
    misrReg = Gold;
    start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 bistDone = 1;
    @(posedge clk); #1;
    check("midRst.inUnload", 32'(ifA.misrShiftEn), 1);
    repeat (7) @(posedge clk);
    #1 rstN = 0;
    #1;
    check("midRst.shiftEn", 32'(ifA.misrShiftEn), 0);
    check("midRst.signature", 32'(ifA.signature), 0);
    check("midRst.busy", 32'(ifA.busy), 0);
    check("midRstB.shiftEn", 32'(ifB.misrShiftEn), 0);
    bistDone = 0;
    @(posedge clk); #3 rstN = 1;
    session(4, Gold, 0, 0);

    waitIdle(100);
    repeat (5) @(posedge clk);
    #1;
    check("scoreboardA.drained", 32'(q0.size()), 0);
    check("scoreboardB.drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
